kernel_jacobi_2d_mul_pipe: RTL and testbench
============================================

Name: kernel_jacobi_2d_mul_pipe

Overview:
- Parametrised, pipelined integer multiplier for HLS datapath kernels (jacobi-2d address/coefficient products).
- Generalises the single-stage unsigned DSP48 multiplier with:
  - a configurable register-stage count,
  - per-sample signed/unsigned mode,
  - clock-enable stalling,
  - a valid bit that travels with the data,
  - configurable output width.
- Instantiated by the HLS-generated FSM wherever a multi-cycle multiply is scheduled.

Parameters:
- ID, 1, instance identifier; no functional effect.
- NUM_STAGE, 3, number of register stages (latency in enabled cycles); legal range 1..8.
- din0_WIDTH, 10, width of operand a.
- din1_WIDTH, 11, width of operand b.
- dout_WIDTH, 21, width of result.

Ports:
- ap_clk  in  1  clock; all state changes on its rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- ce  in  1  clock enable; low freezes the entire pipeline.
- in_valid  in  1  din0/din1/is_signed carry a sample this cycle.
- is_signed  in  1  1 = both operands two's complement; 0 = both unsigned.
- din0  in  din0_WIDTH  operand a.
- din1  in  din1_WIDTH  operand b.
- dout  out  dout_WIDTH  product.
- out_valid  out  1  dout holds a valid product.

Behaviour:
- Reset: ap_rst_n low asynchronously clears every stage register (operands, mode, partial product, valid).
  - dout = 0 and out_valid = 0 while in reset and after release, until a sample propagates.
  - Release is sampled on ap_clk.
- Stage 1 registers din0, din1, is_signed and in_valid when ce = 1.
- The full product P has width W = din0_WIDTH + din1_WIDTH and is computed from the stage-1 registers:
  - is_signed = 1: P = sign-extended a × sign-extended b.
  - is_signed = 0: P = zero-extended a × zero-extended b.
- Stages 2..NUM_STAGE are a shift chain of {P, valid, mode}; dout and out_valid come from the last stage.
- NUM_STAGE = 1: the product is combinational from the stage-1 registers.
- Latency: a sample presented with in_valid = 1 in enabled cycle k appears with out_valid = 1 after exactly NUM_STAGE enabled edges. Disabled cycles do not count.
- Throughput: one sample per enabled cycle. Back-to-back samples keep order and produce back-to-back outputs.
- ce = 0: no register changes, including valid bits. dout and out_valid hold their values indefinitely. in_valid is ignored.
- in_valid = 0 with ce = 1: a bubble (valid = 0) enters the chain. Operand registers may still load; dout for invalid slots is don't-care but must be deterministic.
- Output width rule:
  - dout_WIDTH < W: dout = P[dout_WIDTH-1:0] (truncation).
  - dout_WIDTH > W: sign-extend if that sample's mode is signed, else zero-extend.
  - dout_WIDTH = W: pass-through.
- Mode is per sample: mixed signed/unsigned samples in flight must not interfere.
- Reset mid-operation: all in-flight samples are discarded. No stale out_valid may be asserted after reset release.
- ce asserted during reset has no effect.
- No overflow flag; truncation is silent.

Test Plan:
- Unsigned max, NUM_STAGE=3, defaults:
  - Stimulus: din0=1023, din1=2047, is_signed=0, single in_valid pulse.
  - Response: exactly 3 edges later dout=2094081 (0x1FF401), out_valid=1 for one cycle.
- Signed extension:
  - Stimulus: din0=10'h3FF (-1), din1=11'd5, is_signed=1.
  - Response: dout=21'h1FFFFB (-5).
  - Same operands with is_signed=0: dout=5115.
- Truncation, dout_WIDTH=20:
  - Stimulus: 1023 × 2047 unsigned.
  - Response: dout=1045505.
  - Signed -512 × -1024 at default widths: dout=524288.
- Streaming plus ce stall:
  - Stimulus: samples (1,1), (2,3), (4,5) on consecutive cycles, then ce=0 for 4 cycles after the first output appears.
  - Response: outputs 1, 6, 20 in order. dout/out_valid frozen during the stall. Remaining outputs resume on the following enabled cycles. Total valid outputs = 3.
- Bubbles and mode mixing:
  - Stimulus: valid, bubble, valid pattern with alternating is_signed.
  - Response: out_valid pattern 1,0,1, with each result using its own sample's mode.
- Reset mid-flight:
  - Stimulus: assert ap_rst_n=0 asynchronously (between edges) with 2 samples in flight.
  - Response: dout=0 and out_valid=0 immediately. No out_valid pulse in the NUM_STAGE cycles after release.
  - Repeat with NUM_STAGE=1 and NUM_STAGE=8 for the latency checks.

Source files
------------

// File: rtl/kernel_jacobi_2d_mul_pipe.sv
// Pipelined signed/unsigned integer multiplier for HLS datapath kernels.
// A valid bit and the per-sample mode travel with each product through a NUM_STAGE-deep chain.
module kernel_jacobi_2d_mul_pipe #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 10,
  parameter int din1_WIDTH = 11,
  parameter int dout_WIDTH = 21
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic                  is_signed,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  out_valid
);

  localparam int W = din0_WIDTH + din1_WIDTH;
  localparam int unused_id = ID;

  // Stage 1: operand capture.
  logic [din0_WIDTH-1:0] a_q;
  logic [din1_WIDTH-1:0] b_q;
  logic                  sgn_q;
  logic                  vld_q;

  // NOTE: data registers are reset too, so dout reads 0 after reset and bubbles stay deterministic.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
      vld_q <= 1'b0;
    end else if (ce) begin
      // NOTE: non-blocking assignments keep every stage reading the pre-edge value of its neighbour.
      a_q   <= din0;
      b_q   <= din1;
      sgn_q <= is_signed;
      vld_q <= in_valid;
    end
  end

  // Extending both operands to W bits makes the low W bits of one unsigned multiply exact in either mode.
  logic [W-1:0] a_ext;
  logic [W-1:0] b_ext;
  logic [W-1:0] prod;

  always_comb begin
    a_ext = {{din1_WIDTH{sgn_q & a_q[din0_WIDTH-1]}}, a_q};
    b_ext = {{din0_WIDTH{sgn_q & b_q[din1_WIDTH-1]}}, b_q};
    prod  = a_ext * b_ext;
  end

  logic [W-1:0] p_last;
  logic         v_last;
  logic         m_last;

  generate
    if (NUM_STAGE == 1) begin : g_comb
      assign p_last = prod;
      assign v_last = vld_q;
      assign m_last = sgn_q;
    end else begin : g_chain
      localparam int D = NUM_STAGE - 1;

      logic [W-1:0] p_q [D];
      logic [D-1:0] v_q;
      logic [D-1:0] m_q;

      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          for (int i = 0; i < D; i++) begin
            p_q[i] <= '0;
          end
          v_q <= '0;
          m_q <= '0;
        end else if (ce) begin
          p_q[0] <= prod;
          v_q[0] <= vld_q;
          m_q[0] <= sgn_q;
          for (int i = 1; i < D; i++) begin
            p_q[i] <= p_q[i-1];
            v_q[i] <= v_q[i-1];
            m_q[i] <= m_q[i-1];
          end
        end
      end

      assign p_last = p_q[D-1];
      assign v_last = v_q[D-1];
      assign m_last = m_q[D-1];
    end
  endgenerate

  // Width adaptation uses the mode that travelled with this particular sample.
  generate
    if (dout_WIDTH < W) begin : g_trunc
      logic unused_bits;
      assign dout        = p_last[dout_WIDTH-1:0];
      assign unused_bits = ^{p_last[W-1:dout_WIDTH], m_last};
    end else if (dout_WIDTH > W) begin : g_extend
      assign dout = {{(dout_WIDTH-W){m_last & p_last[W-1]}}, p_last};
    end else begin : g_pass
      logic unused_mode;
      assign dout        = p_last;
      assign unused_mode = m_last;
    end
  endgenerate

  assign out_valid = v_last;

endmodule

// File: tb/tb_kernel_jacobi_2d_mul_pipe.sv
// Bench for kernel_jacobi_2d_mul_pipe: four instances (latency 1, 3, 8 and a 20-bit output)
// share one stimulus stream and are compared every cycle against a slot-history model.
module tb_kernel_jacobi_2d_mul_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ce = 1'b0;
  logic        in_valid = 1'b0;
  logic        is_signed = 1'b0;
  logic [9:0]  din0 = '0;
  logic [10:0] din1 = '0;

  logic [20:0] dout3, dout1, dout8;
  logic [19:0] dout20;
  logic        ov3, ov1, ov8, ov20;

  always #5 clk = ~clk;

  kernel_jacobi_2d_mul_pipe #(.NUM_STAGE(3)) dut3 (
    .ap_clk(clk), .ap_rst_n(rst_n), .ce(ce), .in_valid(in_valid), .is_signed(is_signed),
    .din0(din0), .din1(din1), .dout(dout3), .out_valid(ov3));

  kernel_jacobi_2d_mul_pipe #(.NUM_STAGE(1)) dut1 (
    .ap_clk(clk), .ap_rst_n(rst_n), .ce(ce), .in_valid(in_valid), .is_signed(is_signed),
    .din0(din0), .din1(din1), .dout(dout1), .out_valid(ov1));

  kernel_jacobi_2d_mul_pipe #(.NUM_STAGE(8)) dut8 (
    .ap_clk(clk), .ap_rst_n(rst_n), .ce(ce), .in_valid(in_valid), .is_signed(is_signed),
    .din0(din0), .din1(din1), .dout(dout8), .out_valid(ov8));

  kernel_jacobi_2d_mul_pipe #(.NUM_STAGE(3), .dout_WIDTH(20)) dut20 (
    .ap_clk(clk), .ap_rst_n(rst_n), .ce(ce), .in_valid(in_valid), .is_signed(is_signed),
    .din0(din0), .din1(din1), .dout(dout20), .out_valid(ov20));

  typedef struct {
    bit          v;
    bit          s;
    logic [9:0]  a;
    logic [10:0] b;
  } slot_t;

  slot_t       hist[$];   // one entry per enabled edge since the last reset
  logic [63:0] cap[$];    // dut3 valid outputs, one per enabled edge
  logic        last_en = 1'b0;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Exact mathematical product in 64 bits; the low output-width bits give truncation or extension.
  function automatic logic [63:0] true_prod(input slot_t e);
    longint x, y;
    x = e.s ? longint'($signed(e.a)) : longint'({54'd0, e.a});
    y = e.s ? longint'($signed(e.b)) : longint'({53'd0, e.b});
    return 64'(x * y);
  endfunction

  task automatic compare_one(input string name, input int n, input int w,
                             input logic ov, input logic [63:0] d);
    logic [63:0] mask;
    slot_t       e;
    mask = (64'd1 << w) - 64'd1;
    if (hist.size() < n) begin
      check({name, " idle valid"}, {63'd0, ov}, 64'd0);
      check({name, " idle dout"}, d, 64'd0);
    end else begin
      e = hist[hist.size() - n];
      check({name, " valid"}, {63'd0, ov}, {63'd0, e.v});
      if (e.v) check({name, " dout"}, d, true_prod(e) & mask);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      last_en <= 1'b0;
    end else begin
      last_en <= ce;
      if (ce) hist.push_back('{in_valid, is_signed, din0, din1});
    end
  end

  always @(negedge clk) begin
    compare_one("ns3", 3, 21, ov3, 64'(dout3));
    compare_one("ns1", 1, 21, ov1, 64'(dout1));
    compare_one("ns8", 8, 21, ov8, 64'(dout8));
    compare_one("w20", 3, 20, ov20, 64'(dout20));
    if (last_en && ov3) cap.push_back(64'(dout3));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit c, input bit v, input bit s,
                       input logic [9:0] a, input logic [10:0] b);
    ce        = c;
    in_valid  = v;
    is_signed = s;
    din0      = a;
    din1      = b;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ns3 valid"}, 64'(ov3), 64'd0);
    check({tag, " ns3 dout"}, 64'(dout3), 64'd0);
    check({tag, " ns1 valid"}, 64'(ov1), 64'd0);
    check({tag, " ns1 dout"}, 64'(dout1), 64'd0);
    check({tag, " ns8 valid"}, 64'(ov8), 64'd0);
    check({tag, " ns8 dout"}, 64'(dout8), 64'd0);
    check({tag, " w20 valid"}, 64'(ov20), 64'd0);
    check({tag, " w20 dout"}, 64'(dout20), 64'd0);
  endtask

  // One valid sample followed by bubbles; literal results at each instance's latency.
  task automatic run_single(input string tag, input logic [9:0] a, input logic [10:0] b,
                            input bit s, input logic [63:0] e21, input logic [63:0] e20);
    drive(1'b1, 1'b1, s, a, b);
    tick();
    drive(1'b1, 1'b0, 1'b0, 10'd0, 11'd0);
    check({tag, " ns1 valid"}, 64'(ov1), 64'd1);
    check({tag, " ns1 dout"}, 64'(dout1), e21);
    for (int k = 2; k <= 8; k++) begin
      tick();
      if (k == 2) check({tag, " ns3 early"}, 64'(ov3), 64'd0);
      if (k == 3) begin
        check({tag, " ns3 valid"}, 64'(ov3), 64'd1);
        check({tag, " ns3 dout"}, 64'(dout3), e21);
        check({tag, " w20 dout"}, 64'(dout20), e20);
      end
      if (k == 4) check({tag, " ns3 single pulse"}, 64'(ov3), 64'd0);
      if (k == 7) check({tag, " ns8 early"}, 64'(ov8), 64'd0);
      if (k == 8) begin
        check({tag, " ns8 valid"}, 64'(ov8), 64'd1);
        check({tag, " ns8 dout"}, 64'(dout8), e21);
      end
    end
  endtask

  initial begin
    // Reset with ce and a valid sample present: nothing may load.
    drive(1'b1, 1'b1, 1'b0, 10'd1023, 11'd2047);
    #1 rst_n = 1'b0;
    #2 check_all_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 10'd0, 11'd0);
    repeat (9) tick();

    run_single("umax", 10'd1023, 11'd2047, 1'b0, 64'd2094081, 64'd1045505);
    run_single("sneg", 10'h3FF, 11'd5, 1'b1, 64'h1FFFFB, 64'hFFFFB);
    run_single("uneg", 10'h3FF, 11'd5, 1'b0, 64'd5115, 64'd5115);
    run_single("smin", 10'h200, 11'h400, 1'b1, 64'd524288, 64'd524288);

    // Streaming with a four-cycle stall once the first result appears.
    cap.delete();
    drive(1'b1, 1'b1, 1'b0, 10'd1, 11'd1); tick();
    drive(1'b1, 1'b1, 1'b0, 10'd2, 11'd3); tick();
    drive(1'b1, 1'b1, 1'b0, 10'd4, 11'd5); tick();
    check("stream first valid", 64'(ov3), 64'd1);
    check("stream first dout", 64'(dout3), 64'd1);
    drive(1'b0, 1'b1, 1'b1, 10'd99, 11'd99);
    repeat (4) begin
      tick();
      check("stall valid held", 64'(ov3), 64'd1);
      check("stall dout held", 64'(dout3), 64'd1);
    end
    drive(1'b1, 1'b0, 1'b0, 10'd0, 11'd0);
    tick();
    check("stream second dout", 64'(dout3), 64'd6);
    tick();
    check("stream third dout", 64'(dout3), 64'd20);
    tick();
    check("stream drained", 64'(ov3), 64'd0);
    check("stream output count", 64'(cap.size()), 64'd3);
    if (cap.size() == 3) begin
      check("stream order 0", cap[0], 64'd1);
      check("stream order 1", cap[1], 64'd6);
      check("stream order 2", cap[2], 64'd20);
    end
    repeat (6) tick();

    // Valid / bubble / valid with alternating mode.
    drive(1'b1, 1'b1, 1'b1, 10'h3FD, 11'd7); tick();
    drive(1'b1, 1'b0, 1'b0, 10'd123, 11'd456); tick();
    drive(1'b1, 1'b1, 1'b0, 10'h3FD, 11'd7); tick();
    drive(1'b1, 1'b0, 1'b1, 10'd0, 11'd0);
    check("mix slot0 valid", 64'(ov3), 64'd1);
    check("mix slot0 dout", 64'(dout3), 64'd2097131);
    check("mix slot0 w20", 64'(dout20), 64'd1048555);
    tick();
    check("mix slot1 bubble", 64'(ov3), 64'd0);
    tick();
    check("mix slot2 valid", 64'(ov3), 64'd1);
    check("mix slot2 dout", 64'(dout3), 64'd7147);
    repeat (8) tick();

    // Reset between edges with two samples in flight.
    drive(1'b1, 1'b1, 1'b0, 10'd5, 11'd6); tick();
    drive(1'b1, 1'b1, 1'b1, 10'h3F9, 11'd7); tick();
    #1 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    tick();
    tick();
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 10'd0, 11'd0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("post reset ns3 valid", 64'(ov3), 64'd0);
      check("post reset ns1 valid", 64'(ov1), 64'd0);
      check("post reset ns8 valid", 64'(ov8), 64'd0);
      check("post reset w20 valid", 64'(ov20), 64'd0);
    end

    // Random traffic: stalls, bubbles and mixed modes, checked by the per-cycle comparator.
    repeat (400) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0,
            10'($urandom), 11'($urandom));
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 10'd0, 11'd0);
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
